// File: rtl/alu_control_seq.sv
// ALU control decoder with a multi-cycle sequencer for mult/multu/div/divu.
// Optional sticky illegal-funct trap enabled by defining ALUCTRL_ILLEGAL_TRAP_EN.
module alu_control_seq #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instValid,
  input  logic [5:0] instFunc,
  input  logic [1:0] ALUOp,
  output logic [3:0] ALUOperation,
  output logic       mdStart,
  output logic [1:0] mdOp,
  output logic       stall,
  output logic       hiloWrite,
  output logic       illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       dec_op;
  logic             md_funct;
  logic             md_hit;
  logic             start;

  always_comb begin
    dec_op   = OP_NOP;
    md_funct = 1'b0;
    case (ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b11: dec_op = OP_OR;
      default: begin
        case (instFunc)
          6'b100000, 6'b100001: dec_op = OP_ADD;
          6'b100010, 6'b100011: dec_op = OP_SUB;
          6'b100100: dec_op = OP_AND;
          6'b100101: dec_op = OP_OR;
          6'b100110: dec_op = OP_XOR;
          6'b100111: dec_op = OP_NOR;
          6'b101010: dec_op = OP_SLT;
          6'b101011: dec_op = OP_SLTU;
          6'b000000: dec_op = OP_SLL;
          6'b000010: dec_op = OP_SRL;
          6'b000011: dec_op = OP_SRA;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: md_funct = 1'b1;
          default: dec_op = OP_NOP;
        endcase
      end
    endcase
  end

  assign md_hit = instValid & md_funct;

  // Only IDLE accepts a mul/div; DONE decodes live but never dispatches.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    start        = 1'b0;
    stall        = 1'b0;
    hiloWrite    = 1'b0;
    ALUOperation = dec_op;
    case (state)
      IDLE: begin
        stall = md_hit;
        if (md_hit) begin
          state_n = RUN;
          start   = 1'b1;
          cnt_n   = instFunc[1] ? DIV_LOAD : MUL_LOAD;
        end
      end
      RUN: begin
        stall        = 1'b1;
        ALUOperation = OP_NOP;
        if (cnt == '0) state_n = DONE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      DONE: begin
        hiloWrite = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mdOp    <= '0;
      mdStart <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      mdStart <= start;
      if (start) mdOp <= instFunc[1:0];
    end
  end

`ifdef ALUCTRL_ILLEGAL_TRAP_EN
  logic unknown_funct;
  logic illegal_q;

  // Every legal R-type funct maps to a non-nop code, so nop without md means unknown.
  assign unknown_funct = (ALUOp == 2'b10) & (dec_op == OP_NOP) & ~md_funct;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      illegal_q <= 1'b0;
    else if ((state != RUN) && instValid && unknown_funct)
      illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Self-checking bench for alu_control_seq: timeline-based reference model plus directed literal checks.
// Honours ALUCTRL_ILLEGAL_TRAP_EN for the illegal-trap expectations.
module tb_alu_control_seq;

  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       instValid = 1'b0;
  logic [5:0] instFunc = '0;
  logic [1:0] ALUOp = '0;
  logic [3:0] ALUOperation;
  logic       mdStart;
  logic [1:0] mdOp;
  logic       stall;
  logic       hiloWrite;
  logic       illegal;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_control_seq #(
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .instValid(instValid),
    .instFunc(instFunc),
    .ALUOp(ALUOp),
    .ALUOperation(ALUOperation),
    .mdStart(mdStart),
    .mdOp(mdOp),
    .stall(stall),
    .hiloWrite(hiloWrite),
    .illegal(illegal)
  );

  // Reference model: R-type lookup table and an operation timeline.
  logic [3:0] rtype_op [logic [5:0]];
  bit         active = 1'b0;
  int         iss = 0;
  int         lat = 0;
  int         cyc = 0;
  logic [1:0] m_mdop = '0;
  bit         m_ill = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_decode(logic [1:0] op, logic [5:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0001;
    return rtype_op.exists(f) ? rtype_op[f] : 4'b1111;
  endfunction

  function automatic bit is_md(logic v, logic [1:0] op, logic [5:0] f);
    return v && op == 2'b10 && f[5:2] == 4'b0110;
  endfunction

  // 0 = idle, 1 = executing, 2 = write-back cycle
  function automatic int phase();
    int r;
    if (!active) return 0;
    r = cyc - iss;
    if (r >= 1 && r <= lat) return 1;
    if (r == lat + 1) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    int ph;
    if (!rst) begin
      active = 1'b0;
      m_mdop = '0;
      m_ill  = 1'b0;
    end else begin
      ph = phase();
      if (ph != 1 && instValid && ALUOp == 2'b10 &&
          !is_md(1'b1, ALUOp, instFunc) && !rtype_op.exists(instFunc))
        m_ill = 1'b1;
      if (ph == 0 && is_md(instValid, ALUOp, instFunc)) begin
        active = 1'b1;
        iss    = cyc;
        lat    = instFunc[1] ? DIV_N : MUL_N;
        m_mdop = instFunc[1:0];
      end
      cyc++;
      if (active && cyc > iss + lat + 1) active = 1'b0;
    end
  end

  always @(negedge clk) begin
    int ph;
    if (chk_en) begin
      ph = phase();
      chk("m_stall", 32'(stall),
          32'((ph == 1) ? 1'b1 : (ph == 2) ? 1'b0 : is_md(instValid, ALUOp, instFunc)));
      chk("m_aluop", 32'(ALUOperation),
          32'((ph == 1) ? 4'b1111 : exp_decode(ALUOp, instFunc)));
      chk("m_mdstart", 32'(mdStart), 32'(ph == 1 && cyc == iss + 1));
      chk("m_hilo", 32'(hiloWrite), 32'(ph == 2));
      chk("m_mdop", 32'(mdOp), 32'(m_mdop));
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
      chk("m_illegal", 32'(illegal), 32'(m_ill));
`else
      chk("m_illegal", 32'(illegal), 32'd0);
`endif
    end
  end

  task automatic drive(logic v, logic [1:0] op, logic [5:0] f);
    @(posedge clk);
    #1;
    instValid = v;
    ALUOp     = op;
    instFunc  = f;
  endtask

  task automatic run_md(string nm, logic [5:0] f, int n, bit rand_run);
    int st_cnt = 0, start_cnt = 0, start_at = -1, hilo_cnt = 0, hilo_at = -1;
    logic [1:0] op_at_start = '0;
    drive(1'b1, 2'b10, f);
    for (int k = 0; k < n + 4; k++) begin
      @(negedge clk);
      if (stall) st_cnt++;
      if (mdStart) begin start_cnt++; start_at = k; op_at_start = mdOp; end
      if (hiloWrite) begin hilo_cnt++; hilo_at = k; end
      @(posedge clk);
      #1;
      if (rand_run && k + 1 <= n) begin
        instValid = 1'($urandom_range(0, 1));
        ALUOp     = 2'($urandom_range(0, 3));
        instFunc  = 6'($urandom_range(0, 63));
      end else begin
        instValid = 1'b0;
      end
    end
    chk({nm, "_stall_cycles"}, 32'(st_cnt), 32'(n + 1));
    chk({nm, "_start_count"}, 32'(start_cnt), 32'd1);
    chk({nm, "_start_at"}, 32'(start_at), 32'd1);
    chk({nm, "_mdop"}, 32'(op_at_start), 32'(f[1:0]));
    chk({nm, "_hilo_count"}, 32'(hilo_cnt), 32'd1);
    chk({nm, "_hilo_at"}, 32'(hilo_at), 32'(n + 1));
  endtask

  logic [1:0] d_op [5] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10};
  logic [5:0] d_fn [5] = '{6'b100000, 6'b000000, 6'b100100, 6'b101011, 6'b000011};
  logic [3:0] d_ex [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b1000, 4'b1011};
  logic [5:0] pick [16] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                            6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                            6'b000000, 6'b000010, 6'b000011, 6'b011000, 6'b011001,
                            6'b011011};

  initial begin
    int hilo_seen;
    rtype_op[6'b100000] = 4'b0010; rtype_op[6'b100001] = 4'b0010;
    rtype_op[6'b100010] = 4'b0110; rtype_op[6'b100011] = 4'b0110;
    rtype_op[6'b100100] = 4'b0000; rtype_op[6'b100101] = 4'b0001;
    rtype_op[6'b100110] = 4'b0011; rtype_op[6'b100111] = 4'b1100;
    rtype_op[6'b101010] = 4'b0111; rtype_op[6'b101011] = 4'b1000;
    rtype_op[6'b000000] = 4'b1001; rtype_op[6'b000010] = 4'b1010;
    rtype_op[6'b000011] = 4'b1011;
    rtype_op[6'b011000] = 4'b1111; rtype_op[6'b011001] = 4'b1111;
    rtype_op[6'b011010] = 4'b1111; rtype_op[6'b011011] = 4'b1111;
    chk_en = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mdstart", 32'(mdStart), 32'd0);
    chk("rst_hilo", 32'(hiloWrite), 32'd0);
    chk("rst_mdop", 32'(mdOp), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Single-cycle decode
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, d_op[i], d_fn[i]);
      @(negedge clk);
      chk("dec_op", 32'(ALUOperation), 32'(d_ex[i]));
      chk("dec_stall", 32'(stall), 32'd0);
      chk("dec_hilo", 32'(hiloWrite), 32'd0);
    end
    drive(1'b0, 2'b00, 6'b000000);

    run_md("mult", 6'b011000, MUL_N, 1'b0);
    run_md("divu", 6'b011011, DIV_N, 1'b1);

    // Reset during the 10th execute cycle of a div
    drive(1'b1, 2'b10, 6'b011010);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1 instValid = 1'b0;
    end
    chk("mid_pre_stall", 32'(stall), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_stall", 32'(stall), 32'd0);
    chk("mid_mdstart", 32'(mdStart), 32'd0);
    chk("mid_hilo", 32'(hiloWrite), 32'd0);
    chk("mid_illegal", 32'(illegal), 32'd0);
    chk("mid_mdop", 32'(mdOp), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    hilo_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (hiloWrite || stall) hilo_seen++;
    end
    chk("mid_no_activity", 32'(hilo_seen), 32'd0);

    // Illegal funct
    drive(1'b1, 2'b10, 6'b111111);
    @(negedge clk);
    chk("ill_aluop", 32'(ALUOperation), 32'hF);
    chk("ill_before_edge", 32'(illegal), 32'd0);
    drive(1'b0, 2'b00, 6'b000000);
    repeat (3) begin
      @(negedge clk);
`ifdef ALUCTRL_ILLEGAL_TRAP_EN
      chk("ill_sticky", 32'(illegal), 32'd1);
`else
      chk("ill_tied", 32'(illegal), 32'd0);
`endif
    end

    // Back-to-back: div offered in the write-back cycle of a mult
    drive(1'b1, 2'b10, 6'b011000);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) begin
        instValid = 1'b1; ALUOp = 2'b10; instFunc = 6'b011010;
      end else instValid = 1'b0;
    end
    @(negedge clk);
    chk("b2b_done_hilo", 32'(hiloWrite), 32'd1);
    chk("b2b_done_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("b2b_idle_stall", 32'(stall), 32'd1);
    chk("b2b_idle_hilo", 32'(hiloWrite), 32'd0);
    @(posedge clk);
    #1 instValid = 1'b0;
    @(negedge clk);
    chk("b2b_start", 32'(mdStart), 32'd1);
    chk("b2b_mdop", 32'(mdOp), 32'd2);
    repeat (40) @(posedge clk);

    // Randomized traffic with occasional asynchronous resets
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 399) != 0);
      instValid = ($urandom_range(0, 9) < 7);
      ALUOp     = 2'($urandom_range(0, 3));
      instFunc  = ($urandom_range(0, 3) != 0) ? pick[$urandom_range(0, 15)]
                                              : 6'($urandom_range(0, 63));
    end
    @(posedge clk);
    #1 rst = 1'b1;
    instValid = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Extends the R-type funct decode to the full MIPS ALU set and adds a multi-cycle sequencer for mult/multu/div/divu.
- The sequencer stalls the datapath, starts the mul/div unit, counts its latency and pulses the HI/LO write.
- Sits between the main control unit (ALUOp) and the ALU / mul-div unit.

Parameters:
- MUL_CYCLES, 4, execute cycles for mult/multu; legal range 1..2^CNT_W.
- DIV_CYCLES, 32, execute cycles for div/divu; legal range 1..2^CNT_W.
- CNT_W, 6, width of the latency counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instValid  in  1  instFunc/ALUOp describe a valid instruction this cycle.
- instFunc  in  6  R-type funct field.
- ALUOp  in  2  from main control: 00 add, 01 sub, 10 R-type, 11 or.
- ALUOperation  out  4  ALU op code.
- mdStart  out  1  one-cycle start pulse to the mul/div unit.
- mdOp  out  2  operation held for the mul/div unit: 00 mult, 01 multu, 10 div, 11 divu.
- stall  out  1  freeze PC/IF-ID while high.
- hiloWrite  out  1  one-cycle HI/LO register write enable.
- illegal  out  1  see Optional Feature.

Behaviour:
- Op codes (low 3 bits match the legacy encoding):
  - 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
  - 1000 sltu, 0011 xor, 1100 nor, 1001 sll, 1010 srl, 1011 sra.
  - 1111 nop.
- Decode is combinational, in IDLE and DONE:
  - ALUOp 00 gives add; 01 gives sub; 11 gives or.
  - ALUOp 10 decodes funct:
    - 100000/100001 add, 100010/100011 sub, 100100 and, 100101 or.
    - 100110 xor, 100111 nor, 101010 slt, 101011 sltu.
    - 000000 sll, 000010 srl, 000011 sra.
    - Any other funct gives nop.
- Mul/div funct codes: 011000 mult, 011001 multu, 011010 div, 011011 divu. These make ALUOperation nop.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - md_hit = instValid & ALUOp==10 & funct is a mul/div code.
  - stall = md_hit, combinational, in the same cycle.
  - On md_hit, the next edge enters RUN, registers mdOp = funct[1:0], sets mdStart=1 and loads cnt = MUL_CYCLES-1 (funct[1]=0) or DIV_CYCLES-1 (funct[1]=1).
- RUN:
  - stall=1 and ALUOperation=nop.
  - mdStart is high only in the first RUN cycle.
  - cnt decrements each cycle. The edge after cnt==0 enters DONE.
  - A latency of 1 gives exactly one RUN cycle.
  - instFunc/ALUOp/instValid are ignored in RUN; upstream is held by stall.
- DONE:
  - hiloWrite=1 for exactly one cycle and stall=0.
  - Decode is live. The next edge returns to IDLE.
  - A back-to-back mul/div presented in DONE is not taken. It is held by a stall only from the following IDLE cycle.
- Total stall = 1 (IDLE detect) + N RUN cycles. Dispatch-to-hiloWrite = N+1 edges.
- Reset (rst=0, any time including mid-RUN), asynchronous:
  - state=IDLE, cnt=0, mdOp=00.
  - mdStart=0, hiloWrite=0, illegal=0.
  - stall then follows the combinational IDLE decode.
  - A mid-operation reset abandons the operation with no hiloWrite.
- instValid=0 in IDLE: decode still drives ALUOperation, but no sequencing occurs.

Optional Feature:
- Macro: ALUCTRL_ILLEGAL_TRAP_EN.
- When defined:
  - illegal is a sticky register, set on the edge where IDLE or DONE sees instValid & ALUOp==10 & funct in neither table.
  - It clears only on reset.
- When undefined:
  - illegal is tied 0 and the trap register is not built.
  - An unknown funct still yields nop.

Test Plan:
- Single-cycle decode: ALUOp 00 gives 0010; ALUOp 01 gives 0110; ALUOp 10 with funct 100100 gives 0000, 101011 gives 1000, 000011 gives 1011. stall=0 and hiloWrite=0 throughout.
- mult: instValid=1, ALUOp=10, funct=011000, default params. Expect stall high for 5 cycles; mdStart pulses 1 cycle with mdOp=00; hiloWrite pulses 1 cycle after the 4th RUN cycle.
- divu: funct=011011. Expect 32 RUN cycles, mdOp=11 and hiloWrite after 33 edges. Inputs toggled randomly during RUN have no effect.
- Reset mid-RUN: assert rst=0 at RUN cycle 10 of div. Expect immediate IDLE, mdStart/hiloWrite/illegal=0; with inputs idle, stall=0 and no hiloWrite.
- Back-to-back: present mult, then present div in the DONE cycle. Expect div not taken in DONE (stall=0), taken in the next IDLE cycle, mdOp=10.
- With ALUCTRL_ILLEGAL_TRAP_EN: funct 111111 with ALUOp=10 gives ALUOperation 1111 and illegal=1 from the next edge until reset. Without the macro, illegal stays 0.
